// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-access definitions for the store buffer.
//   SZ_BYTE/SZ_HALF/SZ_WORD - MemSrc size codes (bits [1:0])
//   sb_entry_t              - pending store {addr, data, size}
//   size_bytes()            - byte count of an access from its MemSrc code
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } sb_entry_t;

  // Codes 10 and 11 are both treated as word accesses.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size[1:0])
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: pipeline store/load request and data-memory port bundle.
//   st_*   - store request (valid/addr/data/size) and st_ready
//   ld_*   - load request (valid/addr/size) and ld_stall
//   mem_*  - data memory port (A, WD, WE, MemSrc); empty = no pending stores
//   fwd_*  - forwarded load data, only with STORE_BUFFER_FWD_EN defined
// slave = store buffer side, master = pipeline/memory side.
interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_size;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic        ld_stall;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [2:0]  mem_MemSrc;
  logic        empty;
`ifdef STORE_BUFFER_FWD_EN
  logic        fwd_valid;
  logic [31:0] fwd_data;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    output st_ready, ld_stall, mem_A, mem_WD, mem_WE, mem_MemSrc, empty,
           fwd_valid, fwd_data
  );
  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    input  st_ready, ld_stall, mem_A, mem_WD, mem_WE, mem_MemSrc, empty,
           fwd_valid, fwd_data
  );
`else
  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    output st_ready, ld_stall, mem_A, mem_WD, mem_WE, mem_MemSrc, empty
  );
  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    input  st_ready, ld_stall, mem_A, mem_WD, mem_WE, mem_MemSrc, empty
  );
`endif
endinterface

// File: rtl/store_buffer_span_overlap.sv
// span_overlap: combinational byte-span overlap test of two accesses.
//   i_a_addr/i_a_size, i_b_addr/i_b_size - access address and MemSrc size
//   o_overlap - spans [addr, addr+N-1] share at least one byte
// Span ends are computed in 33 bits so nothing wraps past 0xFFFFFFFF.
module span_overlap
  import mem_pkg::*;
(
  input  logic [31:0] i_a_addr,
  input  logic [2:0]  i_a_size,
  input  logic [31:0] i_b_addr,
  input  logic [2:0]  i_b_size,
  output logic        o_overlap
);
  logic [32:0] w_a_hi, w_b_hi;
  assign w_a_hi = {1'b0, i_a_addr} + {30'd0, size_bytes(i_a_size)} - 33'd1;
  assign w_b_hi = {1'b0, i_b_addr} + {30'd0, size_bytes(i_b_size)} - 33'd1;
  assign o_overlap = ({1'b0, i_a_addr} <= w_b_hi) && ({1'b0, i_b_addr} <= w_a_hi);
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores sharing one data-memory port
// with loads. Loads own the port unless they overlap a pending store (then
// ld_stall and the buffer drains); otherwise the head entry drains.
//   clk, rst_n - clock, synchronous active-low reset
//   sb         - store_buffer_if.slave (store/load requests, memory port)
// Optional: STORE_BUFFER_FWD_EN adds store-to-load forwarding on an exact
// addr/size match with the youngest overlapping entry (fwd_valid/fwd_data).
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_live, w_ovl;
  logic             w_hit, w_stall_ovl, w_ld_go, w_drain, w_push;
  sb_entry_t        w_head;

  // Slot g is live when its age (distance from the read pointer) < count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] w_age;
    assign w_age     = PW'(g) - r_rptr;
    assign w_live[g] = {1'b0, w_age} < r_count;
    span_overlap u_ov (
      .i_a_addr (sb.ld_addr),
      .i_a_size (sb.ld_size),
      .i_b_addr (r_mem[g].addr),
      .i_b_size (r_mem[g].size),
      .o_overlap(w_ovl[g])
    );
  end

  assign w_hit  = |(w_live & w_ovl);
  assign w_head = r_mem[r_rptr];

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] w_young;
  logic          w_fwd_ok;
  sb_entry_t     w_yent;

  // Walk oldest to youngest; the last live overlapping slot wins.
  always_comb begin
    w_young = r_rptr;
    for (int k = 0; k < DEPTH; k++)
      if ((CW'(k) < r_count) && w_ovl[r_rptr + PW'(k)]) w_young = r_rptr + PW'(k);
  end

  assign w_yent      = r_mem[w_young];
  assign w_fwd_ok    = (w_yent.addr == sb.ld_addr) && (w_yent.size[1:0] == sb.ld_size[1:0]);
  assign w_stall_ovl = w_hit && !w_fwd_ok;
  assign sb.fwd_valid = rst_n && sb.ld_valid && w_hit && w_fwd_ok;

  // Same extension as the memory load path: ld_size[2]=1 means unsigned.
  always_comb begin
    sb.fwd_data = '0;
    if (sb.fwd_valid)
      case (sb.ld_size[1:0])
        SZ_BYTE: sb.fwd_data = sb.ld_size[2] ? {24'd0, w_yent.data[7:0]}
                                             : {{24{w_yent.data[7]}}, w_yent.data[7:0]};
        SZ_HALF: sb.fwd_data = sb.ld_size[2] ? {16'd0, w_yent.data[15:0]}
                                             : {{16{w_yent.data[15]}}, w_yent.data[15:0]};
        default: sb.fwd_data = w_yent.data;
      endcase
  end
`else
  assign w_stall_ovl = w_hit;
`endif

  // Outputs are forced to their idle values while rst_n is low.
  assign sb.ld_stall = rst_n && sb.ld_valid && w_stall_ovl;
  assign w_ld_go     = rst_n && sb.ld_valid && !w_stall_ovl;
  assign w_drain     = rst_n && !w_ld_go && (r_count != '0);
  assign sb.st_ready = !rst_n || (r_count != CW'(DEPTH));
  assign sb.empty    = !rst_n || (r_count == '0);
  assign w_push      = rst_n && sb.st_valid && (r_count != CW'(DEPTH));

  always_comb begin
    sb.mem_A      = '0;
    sb.mem_WD     = '0;
    sb.mem_WE     = 1'b0;
    sb.mem_MemSrc = '0;
    if (w_ld_go) begin
      sb.mem_A      = sb.ld_addr;
      sb.mem_MemSrc = sb.ld_size;
    end else if (w_drain) begin
      sb.mem_A      = w_head.addr;
      sb.mem_WD     = w_head.data;
      sb.mem_WE     = 1'b1;
      sb.mem_MemSrc = w_head.size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{addr: sb.st_addr, data: sb.st_data, size: sb.st_size};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_drain) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_drain)      r_count <= r_count + 1'b1;
      else if (!w_push && w_drain) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if sb();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_push = 0, exp_pop = 0;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic longint unsigned nbytes(input logic [2:0] s);
    if (s[1:0] == 2'b00) return 1;
    if (s[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ovl(input logic [31:0] a, input logic [2:0] sa,
                             input logic [31:0] b, input logic [2:0] sb_);
    longint unsigned alo, ahi, blo, bhi;
    alo = a; ahi = alo + nbytes(sa) - 1;
    blo = b; bhi = blo + nbytes(sb_) - 1;
    return !(ahi < blo || bhi < alo);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs from the model for the current inputs.
  task automatic compare();
    bit hit = 0, fwd = 0, stall, go, we;
    int yi = -1;
    logic [31:0] ea = 0, ewd = 0, efd = 0;
    logic [2:0]  esrc = 0;
    if (!rst_n) begin
      chk("rst_st_ready", sb.st_ready, 1); chk("rst_empty", sb.empty, 1);
      chk("rst_ld_stall", sb.ld_stall, 0); chk("rst_mem_WE", sb.mem_WE, 0);
      chk("rst_mem_A", sb.mem_A, 0);       chk("rst_mem_WD", sb.mem_WD, 0);
      chk("rst_mem_MemSrc", {29'd0, sb.mem_MemSrc}, 0);
      exp_push = 0; exp_pop = 0;
      return;
    end
    foreach (q[i]) if (ovl(sb.ld_addr, sb.ld_size, q[i].a, q[i].s)) begin hit = 1; yi = i; end
    if (FWD && hit && q[yi].a == sb.ld_addr && q[yi].s[1:0] == sb.ld_size[1:0]) fwd = 1;
    stall = sb.ld_valid && hit && !fwd;
    go    = sb.ld_valid && !stall;
    we    = !go && q.size() > 0;
    if (go) begin ea = sb.ld_addr; esrc = sb.ld_size; end
    else if (we) begin ea = q[0].a; ewd = q[0].d; esrc = q[0].s; end
    chk("st_ready", sb.st_ready, (q.size() < DEPTH) ? 1 : 0);
    chk("empty", sb.empty, (q.size() == 0) ? 1 : 0);
    chk("ld_stall", sb.ld_stall, stall ? 1 : 0);
    chk("mem_WE", sb.mem_WE, we ? 1 : 0);
    chk("mem_A", sb.mem_A, ea);
    chk("mem_WD", sb.mem_WD, ewd);
    chk("mem_MemSrc", {29'd0, sb.mem_MemSrc}, {29'd0, esrc});
`ifdef STORE_BUFFER_FWD_EN
    if (sb.ld_valid && fwd) begin
      case (sb.ld_size[1:0])
        2'b00: efd = sb.ld_size[2] ? 32'(q[yi].d[7:0])  : 32'(signed'(q[yi].d[7:0]));
        2'b01: efd = sb.ld_size[2] ? 32'(q[yi].d[15:0]) : 32'(signed'(q[yi].d[15:0]));
        default: efd = q[yi].d;
      endcase
    end
    chk("fwd_valid", sb.fwd_valid, (sb.ld_valid && fwd) ? 1 : 0);
    chk("fwd_data", sb.fwd_data, efd);
`else
    efd = 0;
`endif
    exp_push = sb.st_valid && (q.size() < DEPTH);
    exp_pop  = we;
  endtask

  task automatic model_update();
    if (!rst_n) q.delete();
    else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back('{a: sb.st_addr, d: sb.st_data, s: sb.st_size});
    end
  endtask

  task automatic step(input bit r, input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] ss, input bit lv, input logic [31:0] la,
                      input logic [2:0] ls);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst_n = r;
    sb.st_valid = sv; sb.st_addr = sa; sb.st_data = sd; sb.st_size = ss;
    sb.ld_valid = lv; sb.ld_addr = la; sb.ld_size = ls;
    #1 compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    sb.st_valid = 0; sb.st_addr = 0; sb.st_data = 0; sb.st_size = 0;
    sb.ld_valid = 0; sb.ld_addr = 0; sb.ld_size = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_reset_ready", sb.st_ready, 1);
    chk("lit_reset_empty", sb.empty, 1);

    // Single word store drains next cycle.
    step(1, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 0);
    chk("lit_st_accept", sb.st_ready, 1);
    idle(1);
    chk("lit_drain_we", sb.mem_WE, 1);
    chk("lit_drain_a", sb.mem_A, 32'h100);
    chk("lit_drain_wd", sb.mem_WD, 32'hDEADBEEF);
    idle(1);
    chk("lit_drain_empty", sb.empty, 1);

    // Fill while a non-overlapping load holds the port.
    for (int i = 0; i < 4; i++) step(1, 1, 32'h10 + 32'(4 * i), 32'(i), 3'b010, 1, 32'h1000, 3'b010);
    step(1, 1, 32'h20, 32'h55, 3'b010, 1, 32'h1000, 3'b010);
    chk("lit_full_ready", sb.st_ready, 0);
    chk("lit_full_nodrain", sb.mem_WE, 0);
    step(1, 1, 32'h20, 32'h55, 3'b010, 1, 32'h1000, 3'b010);
    chk("lit_full_hold", sb.st_ready, 0);
    step(1, 1, 32'h20, 32'h55, 3'b010, 0, 0, 0);
    chk("lit_full_drain_we", sb.mem_WE, 1);
    chk("lit_full_drain_a", sb.mem_A, 32'h10);
    chk("lit_no_passthru", sb.st_ready, 0);
    step(1, 1, 32'h20, 32'h55, 3'b010, 0, 0, 0);
    chk("lit_5th_ready", sb.st_ready, 1);
    idle(6);
    chk("lit_fill_empty", sb.empty, 1);

    // Partial overlap stalls until the drain.
    step(1, 1, 32'h202, 32'h1234, 3'b001, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h203, 3'b000);
    chk("lit_ovl_stall", sb.ld_stall, 1);
    chk("lit_ovl_drain_a", sb.mem_A, 32'h202);
    step(1, 0, 0, 0, 0, 1, 32'h203, 3'b000);
    chk("lit_ovl_clear", sb.ld_stall, 0);
    chk("lit_ovl_load_a", sb.mem_A, 32'h203);

    // Adjacent, non-overlapping load.
    step(1, 1, 32'h300, 32'hCAFE0001, 3'b010, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h304, 3'b000);
    chk("lit_adj_nostall", sb.ld_stall, 0);
    chk("lit_adj_load_a", sb.mem_A, 32'h304);
    chk("lit_adj_buffered", sb.empty, 0);
    idle(2);

    // Exact-match forwarding.
    step(1, 1, 32'h400, 32'h80, 3'b000, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h400, 3'b000);
`ifdef STORE_BUFFER_FWD_EN
    chk("lit_fwd_nostall", sb.ld_stall, 0);
    chk("lit_fwd_signed", sb.fwd_data, 32'hFFFFFF80);
    step(1, 0, 0, 0, 0, 1, 32'h400, 3'b100);
    chk("lit_fwd_unsigned", sb.fwd_data, 32'h00000080);
`else
    chk("lit_nofwd_stall", sb.ld_stall, 1);
`endif
    idle(2);

    // Reset discards pending stores.
    for (int i = 0; i < 3; i++) step(1, 1, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 1, 32'h1000, 3'b010);
    step(0, 0, 0, 0, 0, 1, 32'h1000, 3'b010);
    chk("lit_rst_empty", sb.empty, 1);
    chk("lit_rst_we", sb.mem_WE, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_rst_discard_we", sb.mem_WE, 0);
    end

    // Randomized traffic, addresses clustered to provoke overlaps.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] base, sa, la;
      base = ($urandom_range(0, 19) == 0) ? 32'hFFFFFFF8 : 32'h600;
      sa = base + 32'($urandom_range(0, 7));
      la = base + 32'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), sa, $urandom,
           3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4), la, 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-store entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 st_valid  input  1  pipeline store request.
REQ-005 st_addr  input  32  store byte address.
REQ-006 st_data  input  32  store data, right-aligned.
REQ-007 st_size  input  3  store size, MemSrc coding (bits[1:0]: 00 byte, 01 half, else word).
REQ-008 st_ready  output  1  entry available; a store is accepted when st_valid and st_ready are both high.
REQ-009 ld_valid  input  1  pipeline load request this cycle.
REQ-010 ld_addr  input  32  load byte address.
REQ-011 ld_size  input  3  load size, MemSrc coding.
REQ-012 ld_stall  output  1  load overlaps a pending store; the pipeline holds the load.
REQ-013 mem_A, mem_WD  output  32 each  data memory address and write data.
REQ-014 mem_WE  output  1  data memory write enable.
REQ-015 mem_MemSrc  output  3  data memory size/sign code.
REQ-016 empty  output  1  no pending entries; used by fence/halt logic.

Function
REQ-017 The buffer SHALL be an in-order FIFO of {addr, data, size} entries with read/write pointers and a count register (0..DEPTH).
REQ-018 st_ready SHALL equal (count != DEPTH); there is no pass-through when full, even if a drain occurs in the same cycle.
REQ-019 Byte span of an access SHALL be [addr, addr+N-1], with N = 1/2/4 from size[1:0]; overlap is computed on full 32-bit addresses, with no wrap past 0xFFFFFFFF.
REQ-020 ld_stall SHALL be combinational: ld_valid AND (the load span overlaps any valid entry).
REQ-021 The memory port SHALL have one owner per cycle: a non-stalled ld_valid takes it (mem_A=ld_addr, mem_MemSrc=ld_size, mem_WE=0); otherwise, if count>0, the head entry drains (mem_A/WD/MemSrc from head, mem_WE=1).
REQ-022 A head entry SHALL be popped on the rising edge of a cycle in which mem_WE=1; drain latency is 1 cycle per entry, one entry per cycle maximum.
REQ-023 With a stalled load, draining SHALL continue every cycle until the overlap clears; ld_stall then deasserts combinationally.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-025 When idle (no load, count=0), mem_WE SHALL be 0 and mem_A/mem_WD/mem_MemSrc SHALL be 0.
REQ-026 A store accepted in cycle N SHALL become visible to overlap checks from cycle N+1.

Reset
REQ-027 With rst_n low at a clock edge, count, pointers and all entry valid state SHALL clear; pending stores are discarded.
REQ-028 During and after reset: st_ready=1, empty=1, mem_WE=0, ld_stall=0, mem outputs 0.

Configuration
REQ-029 Macro STORE_BUFFER_FWD_EN SHALL control forwarding.
REQ-030 Defined: a load whose addr and size[1:0] both exactly equal those of the youngest overlapping entry SHALL NOT stall; it takes the port as normal and adds outputs fwd_valid (1) and fwd_data (32).
REQ-031 fwd_data SHALL be the entry data, sign- or zero-extended per ld_size[2] as in the memory load path; partial overlaps SHALL still stall.
REQ-032 Undefined: no fwd_* ports SHALL exist, and every overlap SHALL stall.

Structure
REQ-033 Shared package mem_pkg SHALL hold the size codes (SZ_BYTE, SZ_HALF, SZ_WORD), the entry struct typedef, and the size-to-byte-count function.
REQ-034 Sub-module span_overlap (combinational: two addr/size pairs -> overlap bit) SHALL be instantiated per entry.

Verification
REQ-035 Reset, then store word 0x100=0xDEADBEEF with no loads -> accepted; next cycle mem_WE=1, mem_A=0x100, mem_WD=0xDEADBEEF; following cycle empty=1.
REQ-036 Fill 4 stores while ld_valid is held high to a non-overlapping address -> st_ready=0 after the 4th; 5th store held off; no drain until ld_valid drops.
REQ-037 Pending half store at 0x202, then load byte 0x203 -> ld_stall=1 until the drain cycle, then 0 on the next cycle.
REQ-038 Pending word 0x300, then load byte 0x304 -> no stall; load owns the port while the entry stays buffered.
REQ-039 With STORE_BUFFER_FWD_EN: pending store byte 0x80 at 0x400, then load byte signed at 0x400 -> no stall, fwd_data=0xFFFFFF80; the same load as unsigned -> 0x00000080.
REQ-040 Reset asserted with 3 pending entries -> next cycle empty=1, mem_WE=0, and none of the 3 entries is ever written.
